// File: rtl/synch_updown_counter.sv
// synch_updown_counter: parametrised synchronous up/down counter with a
// programmable modulus, parallel load, wrap or saturate end-of-range handling,
// a combinational terminal-count flag, a registered wrap pulse and a registered
// Gray-coded copy of the count.
module synch_updown_counter #(
    parameter int unsigned SIZE     = 4,
    parameter int unsigned MOD      = 16,
    parameter int unsigned SATURATE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            up,
    input  logic            load,
    input  logic [SIZE-1:0] D,
    output logic [SIZE-1:0] Q,
    output logic [SIZE-1:0] Q_gray,
    output logic            tc,
    output logic            wrap
);

    localparam int unsigned EXT_W = SIZE + 1;
    localparam logic [SIZE-1:0]  LAST    = SIZE'(MOD - 1);
    localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MOD);
    localparam bit               SAT     = (SATURATE != 0);

    logic [SIZE-1:0] q_next;
    logic [SIZE-1:0] gray_next;
    logic            wrap_next;
    logic [SIZE-1:0] d_clamped;
    logic            at_last;
    logic            at_first;

    assign at_last  = (Q == LAST);
    assign at_first = (Q == '0);

    // Out-of-range load values are clamped to the top of the count range.
    always_comb begin
        d_clamped = LAST;
        if ({1'b0, D} < MOD_EXT) begin
            d_clamped = D;
        end
    end

    // Terminal count: enabled and sitting at the end of range for this direction.
    always_comb begin
        tc = 1'b0;
        if (en) begin
            tc = up ? at_last : at_first;
        end
    end

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = d_clamped;
        end else if (en) begin
            if (up) begin
                if (!at_last) begin
                    q_next = Q + SIZE'(1);
                end else if (!SAT) begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (!at_first) begin
                    q_next = Q - SIZE'(1);
                end else if (!SAT) begin
                    q_next    = LAST;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    // Gray copy is derived from the next count so it lands on the same edge.
    always_comb begin
        gray_next = q_next ^ (q_next >> 1);
    end

    // Count, Gray copy and wrap pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q      <= '0;
            Q_gray <= '0;
            wrap   <= 1'b0;
        end else begin
            Q      <= q_next;
            Q_gray <= gray_next;
            wrap   <= wrap_next;
        end
    end

endmodule

// File: tb/tb_synch_updown_counter.sv
// Self-checking bench for synch_updown_counter: four instances (wrap/saturate,
// several moduli) share one stimulus stream and are compared every cycle with
// an arithmetic reference model, plus directed checks for key sequences.
module tb_synch_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] d;

    logic [3:0] q0, q1, q2, q3;
    logic [3:0] g0, g1, g2, g3;
    logic       tc0, tc1, tc2, tc3;
    logic       w0, w1, w2, w3;

    logic [3:0] qv [4];
    logic [3:0] gv [4];
    logic       tcv[4];
    logic       wv [4];

    int mods[4] = '{10, 10, 16, 2};
    int sats[4] = '{0, 1, 0, 0};
    int mq  [4];
    int mw  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    synch_updown_counter #(.SIZE(4), .MOD(10), .SATURATE(0)) u_w10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .D(d),
        .Q(q0), .Q_gray(g0), .tc(tc0), .wrap(w0));
    synch_updown_counter #(.SIZE(4), .MOD(10), .SATURATE(1)) u_s10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .D(d),
        .Q(q1), .Q_gray(g1), .tc(tc1), .wrap(w1));
    synch_updown_counter #(.SIZE(4), .MOD(16), .SATURATE(0)) u_w16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .D(d),
        .Q(q2), .Q_gray(g2), .tc(tc2), .wrap(w2));
    synch_updown_counter #(.SIZE(4), .MOD(2), .SATURATE(0)) u_w2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .D(d),
        .Q(q3), .Q_gray(g3), .tc(tc3), .wrap(w3));

    assign qv[0] = q0;  assign qv[1] = q1;  assign qv[2] = q2;  assign qv[3] = q3;
    assign gv[0] = g0;  assign gv[1] = g1;  assign gv[2] = g2;  assign gv[3] = g3;
    assign tcv[0] = tc0; assign tcv[1] = tc1; assign tcv[2] = tc2; assign tcv[3] = tc3;
    assign wv[0] = w0;  assign wv[1] = w1;  assign wv[2] = w2;  assign wv[3] = w3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: step the count by +/-1; out-of-range results either wrap
    // modulo MOD or are clamped, depending on the instance.
    task automatic model_edge();
        int t;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                mq[i] = 0;
                mw[i] = 0;
            end else if (load) begin
                mq[i] = (int'(d) < mods[i]) ? int'(d) : mods[i] - 1;
                mw[i] = 0;
            end else if (en) begin
                t = mq[i] + (up ? 1 : -1);
                if (t < 0 || t >= mods[i]) begin
                    mw[i] = (sats[i] == 0) ? 1 : 0;
                    mq[i] = (sats[i] != 0) ? mq[i] : (t + mods[i]) % mods[i];
                end else begin
                    mq[i] = t;
                    mw[i] = 0;
                end
            end else begin
                mw[i] = 0;
            end
        end
    endtask

    // One clock: drive inputs, check tc before the edge, check registers after.
    task automatic cycle(input logic r, input logic l, input logic e,
                         input logic u, input logic [3:0] dv);
        rst = r; load = l; en = e; up = u; d = dv;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tc[%0d]", i), 32'(tcv[i]),
                  32'(en && (up ? (mq[i] == mods[i] - 1) : (mq[i] == 0))));
        end
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("q[%0d]", i), 32'(qv[i]), 32'(mq[i]));
            check($sformatf("gray[%0d]", i), 32'(gv[i]), 32'(mq[i] ^ (mq[i] >> 1)));
            check($sformatf("wrap[%0d]", i), 32'(wv[i]), 32'(mw[i]));
        end
    endtask

    initial begin
        int seq1[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int seq2[5]  = '{2, 1, 0, 9, 8};
        int wraps;
        rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b0; d = '0;
        for (int i = 0; i < 4; i++) begin mq[i] = 0; mw[i] = 0; end
        @(posedge clk); #1;

        // Reset held two cycles; en=1, up=0 makes tc high at reset.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        check("reset_q", 32'(q0), 0);
        check("reset_tc_down", 32'(tc0), 1);

        // Test 1: count up 12 cycles through the wrap.
        wraps = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(0, 0, 1, 1, 0);
            check("t1_seq", 32'(q0), 32'(seq1[k]));
            if (w0) wraps++;
        end
        check("t1_wrap_count", 32'(wraps), 1);

        // Test 2: load 3, count down 5.
        cycle(0, 1, 0, 0, 4'd3);
        check("t2_load", 32'(q0), 3);
        wraps = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 1, 0, 0);
            check("t2_seq", 32'(q0), 32'(seq2[k]));
            if (w0) wraps++;
        end
        check("t2_wrap_count", 32'(wraps), 1);

        // Test 3: clamped load then hold.
        cycle(0, 1, 0, 0, 4'd13);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        check("t3_clamp_q", 32'(q0), 9);
        check("t3_clamp_gray", 32'(g0), 32'(4'b1101));
        check("t3_w16_noclamp", 32'(q2), 13);
        check("t3_w2_clamp", 32'(q3), 1);

        // Test 4: saturate up from 7, then down from 1.
        cycle(0, 1, 0, 0, 4'd7);
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 1, 0);
        check("t4_sat_hi", 32'(q1), 9);
        check("t4_sat_tc", 32'(tc1), 1);
        cycle(0, 1, 0, 0, 4'd1);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        check("t4_sat_lo", 32'(q1), 0);

        // Test 5: simultaneous events and direction toggling.
        cycle(1, 1, 1, 1, 4'd5);
        check("t5_rst_wins", 32'(q0), 0);
        cycle(0, 1, 1, 1, 4'd5);
        check("t5_load_wins", 32'(q0), 5);
        cycle(0, 1, 0, 0, 4'd4);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 1, (k % 2 == 0), 0);
            check("t5_toggle", 32'(q0), (k % 2 == 0) ? 5 : 4);
        end

        // Test 6: full-range modulus across natural overflow, then reset.
        cycle(0, 1, 0, 0, 4'd14);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        check("t6_overflow", 32'(q2), 0);
        check("t6_wrap", 32'(w2), 1);
        cycle(0, 0, 1, 1, 0);
        check("t6_after", 32'(q2), 1);
        cycle(1, 0, 1, 1, 0);
        check("t6_rst_q", 32'(q2), 0);
        check("t6_rst_wrap", 32'(w2), 0);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
